// File: rtl/l2_feeder.sv
// Layer-2 input feeder: walks 3x3 windows over the two layer-1 maps in raster order
// and streams each window tap by tap to layer 2, throttled by wr_cnt and bsy_in.
module l2_feeder #(
    parameter int IN_W = 12,
    parameter int IN_H = 12,
    parameter int AW   = 8,
    parameter int DW   = 18
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_done,
    input  logic [AW-1:0]        wr_cnt,
    output logic [AW-1:0]        addr_rd,
    input  logic signed [DW-1:0] map_0,
    input  logic signed [DW-1:0] map_1,
    input  logic                 bsy_in,
    output logic                 strt,
    output logic signed [DW-1:0] din_0,
    output logic signed [DW-1:0] din_1,
    output logic                 done
);

    localparam int OUT_W = IN_W - 2;
    localparam int OUT_H = IN_H - 2;
    localparam int XW    = $clog2(IN_W);
    localparam int YW    = $clog2(IN_H);

    localparam logic [AW-1:0] ROW_STEP  = AW'(IN_W);
    localparam logic [AW-1:0] BR_OFS    = AW'(2 * IN_W + 2);
    localparam logic [AW-1:0] WRAP_STEP = AW'(IN_W - OUT_W + 1);
    localparam logic [XW-1:0] X_LAST    = XW'(OUT_W - 1);
    localparam logic [YW-1:0] Y_LAST    = YW'(OUT_H - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ISSUE,
        S_HOLD,
        S_DONE
    } state_t;

    state_t          state;
    logic [XW-1:0]   x;
    logic [YW-1:0]   y;
    logic [AW-1:0]   base;     // top-left address of the current window
    logic [AW-1:0]   row;      // start address of the tap row being issued
    logic [1:0]      col;
    logic [3:0]      k;
    logic            tap_vld;  // addr_rd currently carries a live tap

    logic [AW-1:0]   br_addr;
    logic            can_go;
    logic            last_win;

    assign br_addr  = base + BR_OFS;
    assign can_go   = !bsy_in && (br_addr < wr_cnt);
    assign last_win = (x == X_LAST) && (y == Y_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            x       <= '0;
            y       <= '0;
            base    <= '0;
            row     <= '0;
            col     <= '0;
            k       <= '0;
            tap_vld <= 1'b0;
            addr_rd <= '0;
            strt    <= 1'b0;
            din_0   <= '0;
            din_1   <= '0;
            done    <= 1'b0;
        end else if (tx_done) begin
            state   <= S_IDLE;
            x       <= '0;
            y       <= '0;
            base    <= '0;
            row     <= '0;
            col     <= '0;
            k       <= '0;
            tap_vld <= 1'b0;
            addr_rd <= '0;
            strt    <= 1'b0;
            din_0   <= '0;
            din_1   <= '0;
            done    <= 1'b0;
        end else begin
            strt  <= 1'b0;
            // Layer 2 accumulates every cycle, so din must be exactly zero between windows.
            din_0 <= tap_vld ? map_0 : '0;
            din_1 <= tap_vld ? map_1 : '0;
            case (state)
                S_IDLE: begin
                    if (!done) state <= S_WAIT;
                end
                S_WAIT: begin
                    if (can_go) begin
                        strt    <= 1'b1;
                        addr_rd <= base;
                        row     <= base;
                        col     <= '0;
                        k       <= '0;
                        tap_vld <= 1'b1;
                        state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (k == 4'd8) begin
                        tap_vld <= 1'b0;
                        state   <= S_HOLD;
                    end else begin
                        k <= k + 4'd1;
                        if (col == 2'd2) begin
                            col     <= '0;
                            row     <= row + ROW_STEP;
                            addr_rd <= row + ROW_STEP;
                        end else begin
                            col     <= col + 2'd1;
                            addr_rd <= addr_rd + AW'(1);
                        end
                    end
                end
                S_HOLD: begin
                    if (!bsy_in) begin
                        if (last_win) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            if (x == X_LAST) begin
                                x    <= '0;
                                y    <= y + YW'(1);
                                base <= base + WRAP_STEP;
                            end else begin
                                x    <= x + XW'(1);
                                base <= base + AW'(1);
                            end
                            state <= S_WAIT;
                        end
                    end
                end
                S_DONE: begin
                    done <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_l2_feeder.sv
// Bench for l2_feeder: layer-1 storage and layer-2 busy models, a negedge monitor,
// and per-scenario tasks compared against a window/tap address model.
module tb_l2_feeder;

    localparam int IN_W  = 12;
    localparam int IN_H  = 12;
    localparam int AW    = 8;
    localparam int DW    = 18;
    localparam int OUT_W = IN_W - 2;
    localparam int OUT_H = IN_H - 2;
    localparam int NWIN  = OUT_W * OUT_H;

    logic          clk = 1'b0;
    logic          rst;
    logic          tx_done;
    logic [AW-1:0] wr_cnt;
    logic [AW-1:0] addr_rd;
    logic [DW-1:0] map_0, map_1;
    logic          bsy_in;
    logic          strt;
    logic [DW-1:0] din_0, din_1;
    logic          done;

    int   dofs = 1;
    int   busy_len = 10;
    logic force_bsy = 1'b0;
    int   l2_cnt = 0;

    int n_pass = 0;
    int n_chk  = 0;

    l2_feeder #(.IN_W(IN_W), .IN_H(IN_H), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .tx_done(tx_done), .wr_cnt(wr_cnt), .addr_rd(addr_rd),
        .map_0(map_0), .map_1(map_1), .bsy_in(bsy_in), .strt(strt),
        .din_0(din_0), .din_1(din_1), .done(done)
    );

    always #5 clk = ~clk;

    // Layer-1 storage: pixel at address a holds a+dofs on channel 0 and its negative on channel 1.
    assign map_0 = DW'(int'(addr_rd) + dofs);
    assign map_1 = DW'(-(int'(addr_rd) + dofs));

    // Layer-2 model: busy from the cycle after strt for busy_len cycles.
    assign bsy_in = (l2_cnt != 0) || force_bsy;
    always @(posedge clk or posedge rst) begin
        if (rst)                l2_cnt <= 0;
        else if (strt)          l2_cnt <= busy_len;
        else if (l2_cnt != 0)   l2_cnt <= l2_cnt - 1;
    end

    // Monitor: collects tap addresses and din per window, counts protocol violations.
    int cyc = 0, ph = 99, last_strt = -100;
    int n_strt = 0, bsy_viol = 0, gap_viol = 0, zero_viol = 0, early_viol = 0;
    int obs_addr[$];
    int obs_wr[$];
    logic [DW-1:0] obs_d0[$];
    logic [DW-1:0] obs_d1[$];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            ph        <= 99;
            last_strt <= -100;
        end else begin
            if (ph >= 1 && ph <= 9) begin
                obs_d0.push_back(din_0);
                obs_d1.push_back(din_1);
            end else if (din_0 != '0 || din_1 != '0) begin
                zero_viol <= zero_viol + 1;
            end
            if (strt) begin
                n_strt <= n_strt + 1;
                obs_wr.push_back(int'(wr_cnt));
                obs_addr.push_back(int'(addr_rd));
                if (bsy_in) bsy_viol <= bsy_viol + 1;
                if (cyc - last_strt < 11) gap_viol <= gap_viol + 1;
                if (int'(addr_rd) + 2 * IN_W + 2 >= int'(wr_cnt)) early_viol <= early_viol + 1;
                last_strt <= cyc;
                ph <= 1;
            end else begin
                if (ph >= 1 && ph <= 8) obs_addr.push_back(int'(addr_rd));
                if (ph < 99) ph <= ph + 1;
            end
            if (tx_done) begin
                ph        <= 99;
                last_strt <= -100;
            end
        end
    end

    // Reference: address of tap k of window number w in raster order.
    function automatic int tap_addr(int w, int k);
        return (w / OUT_W + k / 3) * IN_W + (w % OUT_W) + (k % 3);
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic restart();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    task automatic test_reset();
        int n0;
        rst = 1'b1; tx_done = 1'b0; wr_cnt = '0; force_bsy = 1'b0;
        dofs = $urandom_range(1, 2000);
        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            n_chk++; if (strt !== 1'b0) $display("FAIL reset_strt got=%0b exp=0", strt); else n_pass++;
            n_chk++; if (din_0 !== '0) $display("FAIL reset_din_0 got=%0h exp=0", din_0); else n_pass++;
            n_chk++; if (din_1 !== '0) $display("FAIL reset_din_1 got=%0h exp=0", din_1); else n_pass++;
            n_chk++; if (addr_rd !== '0) $display("FAIL reset_addr got=%0d exp=0", addr_rd); else n_pass++;
            n_chk++; if (done !== 1'b0) $display("FAIL reset_done got=%0b exp=0", done); else n_pass++;
            tick();
        end
        rst = 1'b0;
        n0 = n_strt;
        repeat (40) tick();
        n_chk++; if (n_strt != n0) $display("FAIL wait_no_data_strt got=%0d exp=0 pulses", n_strt - n0); else n_pass++;
        n_chk++; if (done !== 1'b0) $display("FAIL wait_no_data_done got=%0b exp=0", done); else n_pass++;
    endtask

    task automatic test_full_frame();
        int a0, d0i, n0, bv0, gv0, zv0, ev0, t, n;
        logic pb;
        logic [DW-1:0] e0, e1;
        wr_cnt = AW'(IN_W * IN_H);
        dofs = $urandom_range(1, 2000);
        busy_len = $urandom_range(10, 13);
        restart();
        a0 = obs_addr.size(); d0i = obs_d0.size(); n0 = n_strt;
        bv0 = bsy_viol; gv0 = gap_viol; zv0 = zero_viol; ev0 = early_viol;
        t = 0; pb = bsy_in;
        while (done !== 1'b1 && t < 6000) begin
            pb = bsy_in;
            tick();
            t++;
        end
        n_chk++; if (done !== 1'b1) $display("FAIL frame_done_timeout got=%0b exp=1", done); else n_pass++;
        n_chk++; if (pb !== 1'b0) $display("FAIL frame_done_before_bsy_fall bsy=%0b exp=0", pb); else n_pass++;
        n_chk++; if (n_strt - n0 != NWIN) $display("FAIL frame_strt_count got=%0d exp=%0d", n_strt - n0, NWIN); else n_pass++;
        n_chk++; if (bsy_viol != bv0) $display("FAIL frame_strt_while_bsy got=%0d exp=0", bsy_viol - bv0); else n_pass++;
        n_chk++; if (gap_viol != gv0) $display("FAIL frame_strt_spacing got=%0d exp=0", gap_viol - gv0); else n_pass++;
        n_chk++; if (zero_viol != zv0) $display("FAIL frame_din_idle_nonzero got=%0d exp=0", zero_viol - zv0); else n_pass++;
        n_chk++; if (early_viol != ev0) $display("FAIL frame_strt_before_data got=%0d exp=0", early_viol - ev0); else n_pass++;
        n = obs_addr.size() - a0;
        n_chk++; if (n != NWIN * 9) $display("FAIL frame_tap_count got=%0d exp=%0d", n, NWIN * 9); else n_pass++;
        if (n >= NWIN * 9 && obs_d0.size() - d0i >= NWIN * 9) begin
            for (int w = 0; w < NWIN; w++) begin
                for (int k = 0; k < 9; k++) begin
                    e0 = DW'(tap_addr(w, k) + dofs);
                    e1 = DW'(-(tap_addr(w, k) + dofs));
                    n_chk++;
                    if (obs_addr[a0 + w * 9 + k] != tap_addr(w, k))
                        $display("FAIL frame_addr w=%0d k=%0d got=%0d exp=%0d", w, k, obs_addr[a0 + w * 9 + k], tap_addr(w, k));
                    else n_pass++;
                    n_chk++;
                    if (obs_d0[d0i + w * 9 + k] !== e0)
                        $display("FAIL frame_din_0 w=%0d k=%0d got=%0h exp=%0h", w, k, obs_d0[d0i + w * 9 + k], e0);
                    else n_pass++;
                    n_chk++;
                    if (obs_d1[d0i + w * 9 + k] !== e1)
                        $display("FAIL frame_din_1 w=%0d k=%0d got=%0h exp=%0h", w, k, obs_d1[d0i + w * 9 + k], e1);
                    else n_pass++;
                end
            end
            n_chk++; if (obs_addr[a0 + (NWIN - 1) * 9] != 117) $display("FAIL last_tap0 got=%0d exp=117", obs_addr[a0 + (NWIN - 1) * 9]); else n_pass++;
            n_chk++; if (obs_addr[a0 + NWIN * 9 - 1] != 143) $display("FAIL last_tap8 got=%0d exp=143", obs_addr[a0 + NWIN * 9 - 1]); else n_pass++;
        end
        n = n_strt;
        repeat (20) tick();
        n_chk++; if (done !== 1'b1) $display("FAIL done_held got=%0b exp=1", done); else n_pass++;
        n_chk++; if (n_strt != n) $display("FAIL strt_after_done got=%0d exp=0", n_strt - n); else n_pass++;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        n_chk++; if (done !== 1'b0) $display("FAIL done_clear_on_tx_done got=%0b exp=0", done); else n_pass++;
    endtask

    task automatic test_wr_ramp();
        int a0, n0, ev0, per;
        wr_cnt = '0;
        per = 3;
        restart();
        a0 = obs_addr.size(); n0 = n_strt; ev0 = early_viol;
        for (int i = 0; i < 180; i++) begin
            if (i % per == per - 1 && wr_cnt < AW'(60)) wr_cnt = wr_cnt + AW'(1);
            tick();
        end
        n_chk++; if (n_strt - n0 < 3) $display("FAIL ramp_strt_count got=%0d exp>=3", n_strt - n0); else n_pass++;
        n_chk++; if (early_viol != ev0) $display("FAIL ramp_strt_before_data got=%0d exp=0", early_viol - ev0); else n_pass++;
        if (n_strt - n0 >= 2) begin
            n_chk++; if (obs_wr[n0] != 27) $display("FAIL ramp_first_wr got=%0d exp=27", obs_wr[n0]); else n_pass++;
            n_chk++; if (obs_wr[n0 + 1] < 28) $display("FAIL ramp_second_wr got=%0d exp>=28", obs_wr[n0 + 1]); else n_pass++;
            n_chk++; if (obs_addr[a0] != 0) $display("FAIL ramp_first_addr got=%0d exp=0", obs_addr[a0]); else n_pass++;
            n_chk++; if (obs_addr[a0 + 9] != 1) $display("FAIL ramp_second_addr got=%0d exp=1", obs_addr[a0 + 9]); else n_pass++;
        end
    endtask

    task automatic test_bsy_stall();
        int a0, n0, bv0, t, hold;
        wr_cnt = AW'(IN_W * IN_H);
        busy_len = $urandom_range(10, 12);
        restart();
        a0 = obs_addr.size(); n0 = n_strt; bv0 = bsy_viol;
        t = 0;
        while (n_strt - n0 < 6 && t < 500) begin tick(); t++; end
        n_chk++; if (n_strt - n0 != 6) $display("FAIL stall_reach_w5 got=%0d exp=6", n_strt - n0); else n_pass++;
        force_bsy = 1'b1;
        hold = busy_len + 20 + $urandom_range(0, 5);
        repeat (hold) tick();
        n_chk++; if (n_strt - n0 != 6) $display("FAIL stall_strt_while_forced got=%0d exp=6", n_strt - n0); else n_pass++;
        force_bsy = 1'b0;
        t = 0;
        while (n_strt - n0 < 7 && t < 6) begin tick(); t++; end
        n_chk++; if (n_strt - n0 != 7) $display("FAIL stall_resume got=%0d exp=7", n_strt - n0); else n_pass++;
        t = 0;
        while (n_strt - n0 < 12 && t < 400) begin tick(); t++; end
        repeat (10) tick();
        n_chk++; if (bsy_viol != bv0) $display("FAIL stall_strt_while_bsy got=%0d exp=0", bsy_viol - bv0); else n_pass++;
        n_chk++; if (obs_addr.size() - a0 < 12 * 9) $display("FAIL stall_tap_count got=%0d exp>=108", obs_addr.size() - a0); else n_pass++;
        if (obs_addr.size() - a0 >= 12 * 9) begin
            for (int w = 6; w < 12; w++) begin
                for (int k = 0; k < 9; k++) begin
                    n_chk++;
                    if (obs_addr[a0 + w * 9 + k] != tap_addr(w, k))
                        $display("FAIL stall_addr w=%0d k=%0d got=%0d exp=%0d", w, k, obs_addr[a0 + w * 9 + k], tap_addr(w, k));
                    else n_pass++;
                end
            end
            n_chk++; if (obs_addr[a0 + 10 * 9] != 12) $display("FAIL row_wrap_tap0 got=%0d exp=12", obs_addr[a0 + 10 * 9]); else n_pass++;
        end
    endtask

    task automatic test_abort();
        int n0, a1, d1, t;
        logic [DW-1:0] e0;
        wr_cnt = AW'(IN_W * IN_H);
        busy_len = $urandom_range(10, 13);
        restart();
        n0 = n_strt;
        t = 0;
        while (n_strt - n0 < 4 && t < 400) begin tick(); t++; end
        repeat ($urandom_range(0, 6)) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        n_chk++; if (din_0 !== '0) $display("FAIL abort_din_0 got=%0h exp=0", din_0); else n_pass++;
        n_chk++; if (din_1 !== '0) $display("FAIL abort_din_1 got=%0h exp=0", din_1); else n_pass++;
        n_chk++; if (strt !== 1'b0) $display("FAIL abort_strt got=%0b exp=0", strt); else n_pass++;
        a1 = obs_addr.size(); d1 = obs_d0.size(); n0 = n_strt;
        t = 0;
        while (n_strt == n0 && t < 100) begin tick(); t++; end
        repeat (10) tick();
        n_chk++; if (obs_addr.size() - a1 < 9) $display("FAIL abort_restart_taps got=%0d exp>=9", obs_addr.size() - a1); else n_pass++;
        if (obs_addr.size() - a1 >= 9 && obs_d0.size() - d1 >= 9) begin
            for (int k = 0; k < 9; k++) begin
                n_chk++;
                if (obs_addr[a1 + k] != tap_addr(0, k))
                    $display("FAIL abort_restart_addr k=%0d got=%0d exp=%0d", k, obs_addr[a1 + k], tap_addr(0, k));
                else n_pass++;
            end
            e0 = DW'(dofs);
            n_chk++; if (obs_d0[d1] !== e0) $display("FAIL abort_restart_din_0 got=%0h exp=%0h", obs_d0[d1], e0); else n_pass++;
        end
        n_chk++; if (done !== 1'b0) $display("FAIL abort_restart_done got=%0b exp=0", done); else n_pass++;

        // Reset while the window after (0,0) sits in HOLD.
        n0 = n_strt;
        t = 0;
        while (n_strt == n0 && t < 100) begin tick(); t++; end
        repeat (10) tick();
        rst = 1'b1;
        #1;
        n_chk++; if (addr_rd !== '0) $display("FAIL rst_hold_addr got=%0d exp=0", addr_rd); else n_pass++;
        n_chk++; if (din_0 !== '0 || din_1 !== '0) $display("FAIL rst_hold_din got=%0h/%0h exp=0/0", din_0, din_1); else n_pass++;
        n_chk++; if (strt !== 1'b0 || done !== 1'b0) $display("FAIL rst_hold_flags got=%0b/%0b exp=0/0", strt, done); else n_pass++;
        tick();
        rst = 1'b0;
        a1 = obs_addr.size(); n0 = n_strt;
        t = 0;
        while (n_strt == n0 && t < 100) begin tick(); t++; end
        repeat (10) tick();
        n_chk++; if (obs_addr.size() - a1 < 9) $display("FAIL rst_restart_taps got=%0d exp>=9", obs_addr.size() - a1); else n_pass++;
        if (obs_addr.size() - a1 >= 9) begin
            for (int k = 0; k < 9; k++) begin
                n_chk++;
                if (obs_addr[a1 + k] != tap_addr(0, k))
                    $display("FAIL rst_restart_addr k=%0d got=%0d exp=%0d", k, obs_addr[a1 + k], tap_addr(0, k));
                else n_pass++;
            end
        end
        n_chk++; if (done !== 1'b0) $display("FAIL rst_restart_done got=%0b exp=0", done); else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        tx_done = 1'b0;
        wr_cnt = '0;
        test_reset();
        test_full_frame();
        test_wr_ramp();
        test_bsy_stall();
        test_abort();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
